// File: rtl/alu.sv
// Registered 15-bit ones'-complement ALU: add/sub/mask/multiply/divide on
// parity-tagged 16-bit words (data in [15:1], parity bit ignored).
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [2:0]  command,
  output logic [14:0] res
);

  typedef enum logic [2:0] {
    CMD_AD   = 3'd0,
    CMD_SU   = 3'd1,
    CMD_MASK = 3'd2,
    CMD_MP0  = 3'd3,
    CMD_MP1  = 3'd4,
    CMD_DV0  = 3'd5,
    CMD_DV1  = 3'd6,
    CMD_ZERO = 3'd7
  } cmd_e;

  logic [14:0] a, b, b_add;
  logic [15:0] sum;
  logic [14:0] add_res;
  logic [13:0] ma, mb;
  logic        mul_sign, div_sign;
  logic [27:0] prod;
  logic [13:0] quo, rem;
  logic [14:0] res_d, res_q;

  always_comb begin
    a     = A[15:1];
    b     = B[15:1];
    b_add = (cmd_e'(command) == CMD_SU) ? ~b : b;
    // End-around carry folds the 16th sum bit back into the LSB.
    sum     = {1'b0, a} + {1'b0, b_add};
    add_res = sum[14:0] + {14'b0, sum[15]};

    ma       = a[14] ? ~a[13:0] : a[13:0];
    mb       = b[14] ? ~b[13:0] : b[13:0];
    mul_sign = a[14] ^ b[14];
    div_sign = a[14] ^ b[14];
    prod     = {14'b0, ma} * {14'b0, mb};

    if (mb == '0) begin
      quo = '1;
      rem = '0;
    end else begin
      quo = ma / mb;
      rem = ma % mb;
    end

    res_d = '0;
    unique case (cmd_e'(command))
      CMD_AD, CMD_SU: res_d = add_res;
      CMD_MASK:       res_d = a & b;
      CMD_MP0:        res_d = {15{mul_sign}} ^ {1'b0, prod[27:14]};
      CMD_MP1:        res_d = {15{mul_sign}} ^ {1'b0, prod[13:0]};
      CMD_DV0:        res_d = {15{div_sign}} ^ {1'b0, quo};
      CMD_DV1:        res_d = (mb == '0) ? a : ({15{a[14]}} ^ {1'b0, rem});
      CMD_ZERO:       res_d = '0;
      default:        res_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) res_q <= '0;
    else        res_q <= res_d;
  end

  assign res = res_q;

endmodule

// File: tb/tb_alu.sv
// Table-driven bench for alu: vectors are applied one per cycle, expected
// results queued at drive time and popped when the registered output appears.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [15:0] A, B;
  logic [2:0]  command;
  logic [14:0] res;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [14:0] a;
    logic [14:0] b;
    logic [2:0]  cmd;
    logic [14:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [14:0] sb_q[$];
  string       sb_name[$];

  alu dut (
    .clk(clk),
    .rst_n(rst_n),
    .A(A),
    .B(B),
    .command(command),
    .res(res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic [14:0] a, input logic [14:0] b,
                     input logic [2:0] cmd, input logic [14:0] exp);
    vec_t v;
    v.name = name; v.a = a; v.b = b; v.cmd = cmd; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Parity bit is randomised to show it has no effect.
  task automatic drive(input logic [14:0] a, input logic [14:0] b, input logic [2:0] cmd);
    A       = {a, 1'($urandom)};
    B       = {b, 1'($urandom)};
    command = cmd;
  endtask

  initial begin
    add("ad_neg0",   15'h0099, 15'h7F66, 3'd0, 15'h7FFF);
    add("ad_35_4",   15'd35,   15'd4,    3'd0, 15'd39);
    add("ad_eac",    15'h7FFE, 15'h0002, 3'd0, 15'h0001);
    add("su_35_4",   15'd35,   15'd4,    3'd1, 15'd31);
    add("su_4_35",   15'd4,    15'd35,   3'd1, 15'h7FE0);
    add("mask",      15'h7F0F, 15'h00FF, 3'd2, 15'h000F);
    add("mp0_neg",   15'd35,   15'h7FFB, 3'd3, 15'h7FFF);
    add("mp1_neg",   15'd35,   15'h7FFB, 3'd4, 15'h7F73);
    add("mp0_big",   15'h3FFF, 15'h0002, 3'd3, 15'h0001);
    add("mp1_big",   15'h3FFF, 15'h0002, 3'd4, 15'h3FFE);
    add("mp0_zneg",  15'h0000, 15'h7FFF, 3'd3, 15'h7FFF);
    add("dv0",       15'd100,  15'h7FF8, 3'd5, 15'h7FF1);
    add("dv1",       15'd100,  15'h7FF8, 3'd6, 15'h0002);
    add("dv0_z",     15'd100,  15'h0000, 3'd5, 15'h3FFF);
    add("dv1_z",     15'd100,  15'h0000, 3'd6, 15'd100);
    add("dv0_negz",  15'd100,  15'h7FFF, 3'd5, 15'h4000);
    add("dv1_negz",  15'd100,  15'h7FFF, 3'd6, 15'd100);
    add("cmd7",      15'd35,   15'd4,    3'd7, 15'h0000);
    // back-to-back command changes
    add("b2b_ad",    15'd35,   15'd4,    3'd0, 15'd39);
    add("b2b_su",    15'd35,   15'd4,    3'd1, 15'd31);
    add("b2b_mask",  15'h7F0F, 15'h00FF, 3'd2, 15'h000F);
    add("b2b_mp1",   15'd35,   15'h7FFB, 3'd4, 15'h7F73);
    add("b2b_dv0",   15'd100,  15'h7FF8, 3'd5, 15'h7FF1);
    add("b2b_zero",  15'h7F0F, 15'h00FF, 3'd7, 15'h0000);

    // Reset with arbitrary inputs, no clock edge yet.
    rst_n = 1'b0;
    drive(15'h1234, 15'h0567, 3'd0);
    #1 check("rst_async", res, 15'h0000);
    @(posedge clk); #1;
    check("rst_held", res, 15'h0000);

    // Release: output stays 0 until the next edge, then loads normally.
    @(negedge clk);
    rst_n = 1'b1;
    drive(15'd35, 15'd4, 3'd0);
    #1 check("rst_release_pre", res, 15'h0000);
    @(posedge clk); #1;
    check("rst_release_first", res, 15'd39);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].a, vecs[i].b, vecs[i].cmd);
      sb_q.push_back(vecs[i].exp);
      sb_name.push_back(vecs[i].name);
      @(posedge clk); #1;
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty got none want entry");
      end else begin
        check(sb_name.pop_front(), res, sb_q.pop_front());
      end
    end

    // Mid-stream reset clears immediately, between edges.
    @(negedge clk);
    drive(15'd35, 15'd4, 3'd0);
    @(posedge clk); #1;
    check("pre_midrst", res, 15'd39);
    #2 rst_n = 1'b0;
    #1 check("midrst_async", res, 15'h0000);
    @(posedge clk); #1;
    check("midrst_held", res, 15'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    drive(15'd4, 15'd35, 3'd1);
    @(posedge clk); #1;
    check("midrst_release", res, 15'h7FE0);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d want 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
